// File: rtl/reg_ctrl_pkg.sv
// Shared constants for the register-group access controller: default
// widths, read-FSM state encoding and write-back requester indices.
package reg_ctrl_pkg;

    localparam int DW_DEF   = 16;
    localparam int NREG_DEF = 4;
    localparam int AW_DEF   = 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_CHECK = CHECK,
        S_ISSUE = ISSUE,
        S_RESP  = RESP
    } rd_state_t;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter (ALU, memory load) for the single register
// write port. Grants are combinational; the write port outputs are
// registered, so a grant in cycle N is seen by reg_group in cycle N+1.
// clr_vec is the one-hot of the address granted this cycle, used by the
// scoreboard to retire the pending bit on the same edge the write issues.
module wb_rr_arbiter
    import reg_ctrl_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wa_valid,
    input  logic [AW-1:0]   wa_addr,
    input  logic [DW-1:0]   wa_data,
    output logic            wa_ready,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_addr,
    input  logic [DW-1:0]   wb_data,
    output logic            wb_ready,
    output logic [NREG-1:0] rg_reg_en,
    output logic [DW-1:0]   rg_d_in,
    output logic [NREG-1:0] clr_vec
);

    logic          rr_ptr;
    logic          gnt_a;
    logic          gnt_b;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;

    // Pick at most one requester; rr_ptr only matters when both ask.
    always_comb begin
        gnt_a    = wa_valid && (!wb_valid || (rr_ptr == REQ_ALU));
        gnt_b    = wb_valid && !gnt_a;
        win_addr = gnt_b ? wb_addr : wa_addr;
        win_data = gnt_b ? wb_data : wa_data;
        wa_ready = gnt_a;
        wb_ready = gnt_b;
        clr_vec  = (gnt_a || gnt_b) ? (NREG'(1) << win_addr) : '0;
    end

    // Move the pointer past the winner and register the write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr    <= REQ_ALU;
            rg_reg_en <= '0;
            rg_d_in   <= '0;
        end else begin
            if (gnt_a) begin
                rr_ptr <= REQ_MEM;
            end else if (gnt_b) begin
                rr_ptr <= REQ_ALU;
            end
            rg_reg_en <= clr_vec;
            if (gnt_a || gnt_b) begin
                rg_d_in <= win_data;
            end
        end
    end

endmodule

// File: rtl/reg_access_ctrl.sv
// Register-group access controller: operand-read FSM with busy
// scoreboard plus the write-back arbiter instance.
// Optional feature macro: BUSY_BYPASS_EN -- a register whose pending bit
// is being retired this cycle counts as ready in CHECK, and ISSUE takes
// the value from the write port while it lands.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready for a read request; latch addresses on rd_valid
// CHECK | wait until neither operand register is pending a write
// ISSUE | drive reg_group read; capture operands on rg_en_out
// RESP  | present operands until op_ready
module reg_access_ctrl
    import reg_ctrl_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_valid,
    output logic            rd_ready,
    input  logic [AW-1:0]   rd_addr,
    input  logic [AW-1:0]   rs_addr,
    input  logic            set_busy,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [DW-1:0]   op_rd_q,
    output logic [DW-1:0]   op_rs_q,
    input  logic            wa_valid,
    output logic            wa_ready,
    input  logic [AW-1:0]   wa_addr,
    input  logic [DW-1:0]   wa_data,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [AW-1:0]   wb_addr,
    input  logic [DW-1:0]   wb_data,
    output logic            rg_en_in,
    output logic [AW-1:0]   rg_rd,
    output logic [AW-1:0]   rg_rs,
    input  logic            rg_en_out,
    input  logic [DW-1:0]   rg_rd_q,
    input  logic [DW-1:0]   rg_rs_q,
    output logic [NREG-1:0] rg_reg_en,
    output logic [DW-1:0]   rg_d_in,
    output logic [NREG-1:0] busy
);

    rd_state_t       state;
    rd_state_t       state_nxt;
    logic [AW-1:0]   rd_l;
    logic [AW-1:0]   rs_l;
    logic            sb_l;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] busy_eff;
    logic            hazard;
    logic [DW-1:0]   rd_cap;
    logic [DW-1:0]   rs_cap;

    wb_rr_arbiter #(
        .DW   (DW),
        .NREG (NREG),
        .AW   (AW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .wa_valid  (wa_valid),
        .wa_addr   (wa_addr),
        .wa_data   (wa_data),
        .wa_ready  (wa_ready),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_ready  (wb_ready),
        .rg_reg_en (rg_reg_en),
        .rg_d_in   (rg_d_in),
        .clr_vec   (clr_vec)
    );

    // Operand hazard view and capture source; the bypass build lets a
    // retiring write unblock CHECK and forwards its data into ISSUE.
    always_comb begin
`ifdef BUSY_BYPASS_EN
        busy_eff = busy & ~clr_vec;
        rd_cap   = rg_reg_en[rd_l] ? rg_d_in : rg_rd_q;
        rs_cap   = rg_reg_en[rs_l] ? rg_d_in : rg_rs_q;
`else
        busy_eff = busy;
        rd_cap   = rg_rd_q;
        rs_cap   = rg_rs_q;
`endif
        hazard  = busy_eff[rd_l] | busy_eff[rs_l];
        set_vec = ((state == S_ISSUE) && rg_en_out && sb_l) ? (NREG'(1) << rd_l) : '0;
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read FSM next state and handshake outputs.
    always_comb begin
        state_nxt = state;
        rd_ready  = 1'b0;
        op_valid  = 1'b0;
        rg_en_in  = 1'b0;
        case (state)
            S_IDLE: begin
                rd_ready = 1'b1;
                if (rd_valid) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (!hazard) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                rg_en_in = 1'b1;
                if (rg_en_out) state_nxt = S_RESP;
            end
            S_RESP: begin
                op_valid = 1'b1;
                if (op_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request latch, reg_group address, operand capture and scoreboard.
    // A set and a clear of the same bit in one cycle leaves it set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_l    <= '0;
            rs_l    <= '0;
            sb_l    <= 1'b0;
            rg_rd   <= '0;
            rg_rs   <= '0;
            op_rd_q <= '0;
            op_rs_q <= '0;
            busy    <= '0;
        end else begin
            if ((state == S_IDLE) && rd_valid) begin
                rd_l <= rd_addr;
                rs_l <= rs_addr;
                sb_l <= set_busy;
            end
            if ((state == S_CHECK) && !hazard) begin
                rg_rd <= rd_l;
                rg_rs <= rs_l;
            end
            if ((state == S_ISSUE) && rg_en_out) begin
                op_rd_q <= rd_cap;
                op_rs_q <= rs_cap;
            end
            busy <= (busy & ~clr_vec) | set_vec;
        end
    end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Scoreboard bench for reg_access_ctrl with a behavioural reg_group and
// an architectural register image updated in write-grant order.
module tb_reg_access_ctrl;

    localparam int DW = 16;
    localparam int NREG = 4;
    localparam int AW = 2;
`ifdef BUSY_BYPASS_EN
    localparam int HZ_LAT = 2;
`else
    localparam int HZ_LAT = 3;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            rd_valid, rd_ready, set_busy;
    logic [AW-1:0]   rd_addr, rs_addr;
    logic            op_valid, op_ready;
    logic [DW-1:0]   op_rd_q, op_rs_q;
    logic            wa_valid, wa_ready, wb_valid, wb_ready;
    logic [AW-1:0]   wa_addr, wb_addr;
    logic [DW-1:0]   wa_data, wb_data;
    logic            rg_en_in, rg_en_out;
    logic [AW-1:0]   rg_rd, rg_rs;
    logic [DW-1:0]   rg_rd_q, rg_rs_q;
    logic [NREG-1:0] rg_reg_en;
    logic [DW-1:0]   rg_d_in;
    logic [NREG-1:0] busy;
    logic            en_allow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] rd;
        logic [DW-1:0] rs;
    } op_t;
    op_t exp_q[$];
    op_t mon_e;

    logic [DW-1:0] mem  [NREG] = '{default: '0};
    logic [DW-1:0] arch [NREG] = '{default: '0};

    logic            last_mem;
    logic [NREG-1:0] exp_en;
    logic [DW-1:0]   exp_din;
    logic            pa, pb;

    always #5 clk = ~clk;

    reg_access_ctrl dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rs_addr(rs_addr),
        .set_busy(set_busy),
        .op_valid(op_valid), .op_ready(op_ready), .op_rd_q(op_rd_q), .op_rs_q(op_rs_q),
        .wa_valid(wa_valid), .wa_ready(wa_ready), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .rg_en_in(rg_en_in), .rg_rd(rg_rd), .rg_rs(rg_rs), .rg_en_out(rg_en_out),
        .rg_rd_q(rg_rd_q), .rg_rs_q(rg_rs_q), .rg_reg_en(rg_reg_en), .rg_d_in(rg_d_in),
        .busy(busy)
    );

    // Behavioural reg_group: registered writes, combinational reads.
    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rg_reg_en[i]) mem[i] <= rg_d_in;
        end
    end
    assign rg_en_out = rg_en_in & en_allow;
    assign rg_rd_q = mem[rg_rd];
    assign rg_rs_q = mem[rg_rs];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Operand monitor: pop an expected pair on every op handshake.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
        end else if (op_valid && op_ready) begin
            if (exp_q.size() == 0) begin
                chk("op_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("op_rd_q", 32'(op_rd_q), 32'(mon_e.rd));
                chk("op_rs_q", 32'(op_rs_q), 32'(mon_e.rs));
            end
        end
    end

    // Write monitor: fair alternation between the requesters when both
    // ask, write port one cycle after each grant, register image update.
    always @(negedge clk) begin
        if (!rst) begin
            last_mem = 1'b1;
            exp_en   = '0;
            exp_din  = '0;
        end else begin
            chk("rg_reg_en", 32'(rg_reg_en), 32'(exp_en));
            if (exp_en != '0) chk("rg_d_in", 32'(rg_d_in), 32'(exp_din));
            pa = wa_valid && (!wb_valid || last_mem);
            pb = wb_valid && !pa;
            if (wa_valid || wb_valid) begin
                chk("wa_ready", 32'(wa_ready), 32'(pa));
                chk("wb_ready", 32'(wb_ready), 32'(pb));
            end
            exp_en = '0;
            if (pa) begin
                arch[wa_addr] = wa_data;
                exp_en = NREG'(1) << wa_addr;
                exp_din = wa_data;
                last_mem = 1'b0;
            end else if (pb) begin
                arch[wb_addr] = wb_data;
                exp_en = NREG'(1) << wb_addr;
                exp_din = wb_data;
                last_mem = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a read and hold it until accepted; returns just after the accept edge.
    task automatic rd_issue(input logic [AW-1:0] rd, input logic [AW-1:0] rs, input logic sb,
                            input logic [DW-1:0] erd, input logic [DW-1:0] ers, output int n);
        op_t e;
        n = 0;
        rd_valid = 1'b1;
        rd_addr  = rd;
        rs_addr  = rs;
        set_busy = sb;
        @(negedge clk);
        while (!rd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rd_accept", 32'(rd_ready), 32'd1);
        e.rd = erd;
        e.rs = ers;
        exp_q.push_back(e);
        tick();
        rd_valid = 1'b0;
        set_busy = 1'b0;
    endtask

    // Edges from the previous edge (inclusive) until op_valid is seen.
    task automatic wait_op(output int lat);
        lat = 1;
        @(negedge clk);
        while (!op_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("op_valid_seen", 32'(op_valid), 32'd1);
    endtask

    task automatic wr(input bit use_mem, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        if (use_mem) begin wb_valid = 1'b1; wb_addr = a; wb_data = d; end
        else         begin wa_valid = 1'b1; wa_addr = a; wa_data = d; end
        @(negedge clk);
        while (!(use_mem ? wb_ready : wa_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wr_grant", 32'(use_mem ? wb_ready : wa_ready), 32'd1);
        tick();
        wa_valid = 1'b0;
        wb_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("op_drain", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lat;
        logic ga, gb, prev_a;
        logic [AW-1:0] ra, rb;

        rst = 1'b0; rd_valid = 1'b0; rd_addr = '0; rs_addr = '0; set_busy = 1'b0;
        op_ready = 1'b1; en_allow = 1'b1;
        wa_valid = 1'b0; wa_addr = '0; wa_data = '0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_reg_en", 32'(rg_reg_en), 32'd0);
        chk("rst_op_valid", 32'(op_valid), 32'd0);
        chk("rst_rd_ready", 32'(rd_ready), 32'd1);
        chk("rst_rg_en_in", 32'(rg_en_in), 32'd0);
        chk("rst_op_rd_q", 32'(op_rd_q), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Plain read with minimum latency.
        wr(1'b0, 2'd2, 16'h1234);
        wr(1'b1, 2'd1, 16'h00FF);
        rd_issue(2'd2, 2'd1, 1'b0, 16'h1234, 16'h00FF, n);
        wait_op(lat);
        chk("rd_latency", 32'(lat), 32'd3);
        wait_idle();

        // Hazard: producer marks r3 pending, consumer of r3 stalls until write.
        rd_issue(2'd3, 2'd0, 1'b1, arch[3], arch[0], n);
        wait_idle();
        @(negedge clk);
        chk("hz_busy_set", 32'(busy), 32'b1000);
        tick();
        rd_issue(2'd0, 2'd3, 1'b0, arch[0], 16'hBEEF, n);
        repeat (4) begin
            @(negedge clk);
            chk("hz_stall", 32'(op_valid), 32'd0);
            chk("hz_busy_hold", 32'(busy), 32'b1000);
        end
        tick();
        wr(1'b0, 2'd3, 16'hBEEF);
        wait_op(lat);
        chk("hz_release_lat", 32'(lat), 32'(HZ_LAT));
        wait_idle();
        @(negedge clk);
        chk("hz_busy_clr", 32'(busy), 32'd0);
        tick();

        // Both requesters every cycle: grants must alternate.
        wa_valid = 1'b1; wa_addr = 2'd0;
        wb_valid = 1'b1; wb_addr = 2'd1;
        prev_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wa_data = 16'($urandom);
            wb_data = 16'($urandom);
            @(negedge clk);
            if (i > 0) chk("arb_alternate", 32'(wa_ready), 32'(!prev_a));
            prev_a = wa_ready;
            tick();
        end
        wa_valid = 1'b0;
        wb_valid = 1'b0;
        tick();

        // Set and clear of r2 on the same edge: set wins.
        rd_issue(2'd2, 2'd0, 1'b1, arch[2], arch[0], n);
        tick();
        wa_valid = 1'b1; wa_addr = 2'd2; wa_data = 16'h5A5A;
        @(negedge clk);
        chk("col_in_issue", 32'(rg_en_in), 32'd1);
        tick();
        wa_valid = 1'b0;
        wait_idle();
        @(negedge clk);
        chk("col_busy_set_wins", 32'(busy), 32'b0100);
        tick();
        wr(1'b1, 2'd2, 16'($urandom));
        @(negedge clk);
        chk("col_busy_clr", 32'(busy), 32'd0);
        tick();

        // Backpressure: operands hold, no new request accepted.
        op_ready = 1'b0;
        rd_issue(2'd1, 2'd2, 1'b0, arch[1], arch[2], n);
        wait_op(lat);
        repeat (5) begin
            @(negedge clk);
            chk("bp_op_valid", 32'(op_valid), 32'd1);
            chk("bp_op_rd", 32'(op_rd_q), 32'(arch[1]));
            chk("bp_op_rs", 32'(op_rs_q), 32'(arch[2]));
            chk("bp_rd_ready", 32'(rd_ready), 32'd0);
        end
        tick();
        op_ready = 1'b1;
        rd_issue(2'd0, 2'd3, 1'b0, arch[0], arch[3], n);
        chk("bp_accept_after_hs", 32'(n), 32'd1);
        wait_idle();

        // Reset while stuck in ISSUE with a write in flight.
        en_allow = 1'b0;
        rd_issue(2'd0, 2'd1, 1'b1, arch[0], arch[1], n);
        tick();
        wa_valid = 1'b1; wa_addr = 2'd3; wa_data = 16'hC0DE;
        @(negedge clk);
        chk("mid_issue", 32'(rg_en_in), 32'd1);
        tick();
        wa_valid = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        en_allow = 1'b1;
        @(negedge clk);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_reg_en", 32'(rg_reg_en), 32'd0);
        chk("mrst_op_valid", 32'(op_valid), 32'd0);
        chk("mrst_rd_ready", 32'(rd_ready), 32'd1);
        chk("mrst_rg_en_in", 32'(rg_en_in), 32'd0);
        tick();

        // Random write bursts followed by random reads of the image.
        for (int it = 0; it < 25; it++) begin
            for (int c = 0; c < 10; c++) begin
                if (!wa_valid) begin
                    wa_valid = 1'($urandom_range(0, 1));
                    wa_addr  = 2'($urandom_range(0, 3));
                    wa_data  = 16'($urandom);
                end
                if (!wb_valid) begin
                    wb_valid = 1'($urandom_range(0, 1));
                    wb_addr  = 2'($urandom_range(0, 3));
                    wb_data  = 16'($urandom);
                end
                @(negedge clk);
                ga = wa_ready;
                gb = wb_ready;
                tick();
                if (ga) wa_valid = 1'b0;
                if (gb) wb_valid = 1'b0;
            end
            for (int c = 0; c < 6 && (wa_valid || wb_valid); c++) begin
                @(negedge clk);
                ga = wa_ready;
                gb = wb_ready;
                tick();
                if (ga) wa_valid = 1'b0;
                if (gb) wb_valid = 1'b0;
            end
            chk("rnd_wr_drain", 32'(wa_valid | wb_valid), 32'd0);
            wa_valid = 1'b0;
            wb_valid = 1'b0;
            for (int r = 0; r < 3; r++) begin
                ra = 2'($urandom_range(0, 3));
                rb = 2'($urandom_range(0, 3));
                rd_issue(ra, rb, 1'b0, arch[ra], arch[rb], n);
            end
            wait_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
